// File: rtl/iso14443_2a_pkg.sv
// Shared timing constants, state encoding and Manchester helper for the
// ISO/IEC 14443-2 Type A 106 kbit/s load-modulation path.
package iso14443_2a_pkg;

  localparam int BIT_PERIOD_106K  = 128;
  localparam int HALF_PERIOD_106K = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    DATA = 2'd2,
    EOF  = 2'd3
  } tx_state_e;

  // Subcarrier enable for one Manchester half: a '1' modulates the first half.
  function automatic logic manchester_level(input logic bit_val, input logic second_half);
    return bit_val ^ second_half;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter with synchronous clear, wrap at the bit end,
// and strobes on the last cycle of the first half and of the whole bit.
module bit_timer #(
  parameter int PERIOD = 128,
  parameter int HALF   = PERIOD / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic half_o,
  output logic end_o
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] HALF_LAST = W'(HALF - 1);
  localparam logic [W-1:0] END_LAST  = W'(PERIOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half_o = (cnt_q == HALF_LAST);
  assign end_o  = (cnt_q == END_LAST);

endmodule

// File: rtl/manchester_tx_sequencer.sv
// Frames a serial bit stream as SOF + Manchester data + EOF and drives the
// subcarrier generator enable for Type A PICC load modulation.
module manchester_tx_sequencer
  import iso14443_2a_pkg::*;
#(
  parameter int BIT_PERIOD  = BIT_PERIOD_106K,
  parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic in_ready,
  output logic sc_en,
  output logic busy,
  output logic done,
  output logic underrun
);

  tx_state_e state_q, state_d;
  logic      cur_bit_q, cur_bit_d;
  logic      last_flag_q, last_flag_d;
  logic      sc_en_q, sc_en_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      underrun_q, underrun_d;

  logic      take_bit;
  logic      abort;
  logic      half_stb;
  logic      bit_end;
  logic      timer_clr;

  // Held clear in IDLE so SOF always starts at count 0; other entries happen on the wrap.
  assign timer_clr = (state_q == IDLE);

  bit_timer #(
    .PERIOD (BIT_PERIOD),
    .HALF   (HALF_PERIOD)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (timer_clr),
    .half_o (half_stb),
    .end_o  (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_bit_q   <= 1'b0;
      last_flag_q <= 1'b0;
      sc_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_bit_q   <= cur_bit_d;
      last_flag_q <= last_flag_d;
      sc_en_q     <= sc_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_bit_d   = cur_bit_q;
    last_flag_d = last_flag_q;
    take_bit    = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        // SOF is coded as a '1'; the pending data bit waits for the SOF bit end.
        if (in_valid) begin
          state_d     = SOF;
          cur_bit_d   = 1'b1;
          last_flag_d = 1'b0;
        end
      end
      SOF, DATA: begin
        if (bit_end) begin
          if (last_flag_q) begin
            state_d = EOF;
          end else if (in_valid) begin
            take_bit    = 1'b1;
            state_d     = DATA;
            cur_bit_d   = in_data;
            last_flag_d = in_last;
          end else begin
            abort   = 1'b1;
            state_d = EOF;
          end
        end
      end
      EOF: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = take_bit & ~rst;
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == EOF) && bit_end;
    underrun_d = abort;
    sc_en_d    = sc_en_q;
    // Registered from next state so the level only moves on bit and half-bit boundaries.
    if (state_d == IDLE || state_d == EOF) begin
      sc_en_d = 1'b0;
    end else if (state_q == IDLE || bit_end) begin
      sc_en_d = manchester_level(cur_bit_d, 1'b0);
    end else if (half_stb) begin
      sc_en_d = manchester_level(cur_bit_q, 1'b1);
    end
  end

  assign sc_en    = sc_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_manchester_tx_sequencer.sv
// Scoreboard bench: each frame's per-cycle outputs are predicted from the
// Manchester framing rules and compared cycle by cycle.
module tb_manchester_tx_sequencer;

  localparam int BP = 128;
  localparam int HP = 64;

  logic clk;
  logic rst;
  logic in_valid;
  logic in_data;
  logic in_last;
  logic in_ready;
  logic sc_en;
  logic busy;
  logic done;
  logic underrun;

  // Expected {sc_en, busy, in_ready, done, underrun} per cycle.
  logic [4:0]  exp_q[$];
  int          checks;
  int          errors;

  logic [31:0] src_bits;
  int          src_n;
  int          idx;
  bit          src_last;
  bit          src_en;

  manchester_tx_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .sc_en    (sc_en),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_inputs();
    in_valid = src_en && (idx < src_n);
    in_data  = src_bits[idx[4:0]];
    in_last  = src_last && (idx == src_n - 1);
  endtask

  task automatic load_src(input logic [31:0] bits, input int n, input bit last);
    src_bits = bits;
    src_n    = n;
    src_last = last;
    src_en   = 1'b1;
    idx      = 0;
    drive_inputs();
  endtask

  // Sample outputs mid-cycle, then advance the source if the bit was taken.
  task automatic step(output logic [4:0] obs);
    @(negedge clk);
    obs = {sc_en, busy, in_ready, done, underrun};
    @(posedge clk);
    #1;
    if (obs[2]) idx++;
    drive_inputs();
  endtask

  // n data bits; complete=1 marks the nth bit last, else the source dries up after n.
  task automatic push_frame(input logic [31:0] bits, input int n, input bit complete);
    logic       b;
    logic [4:0] e;
    exp_q.push_back(5'b00000);
    for (int s = 0; s <= n; s++) begin
      b = (s == 0) ? 1'b1 : bits[s-1];
      for (int k = 0; k < BP; k++) begin
        e    = 5'b00000;
        e[4] = b ? (k < HP) : (k >= HP);
        e[3] = 1'b1;
        e[2] = (k == BP - 1) && (s < n);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < BP; k++) begin
      e    = 5'b01000;
      e[0] = !complete && (k == 0);
      exp_q.push_back(e);
    end
    exp_q.push_back(5'b00010);
  endtask

  task automatic test_reset();
    logic [4:0] obs, want;
    int cyc;
    rst = 1'b1;
    load_src(32'b0, 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(obs);
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: outputs=%b expected 00000", c, obs);
      end
    end
    rst = 1'b0;
    push_frame(32'b0, 1, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset_release cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_reset: 5 reset cycles, then frame '0' over %0d cycles", cyc + 1);
  endtask

  task automatic test_single_bit();
    logic [4:0] obs, want;
    int cyc;
    load_src(32'b1, 1, 1'b1);
    push_frame(32'b1, 1, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL single_bit cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_single_bit: frame '1' over %0d cycles", cyc + 1);
  endtask

  task automatic test_frame_0110();
    logic [4:0] obs, want;
    int cyc;
    load_src(32'b0110, 4, 1'b1);
    push_frame(32'b0110, 4, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL frame_0110 cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_frame_0110: frame 0,1,1,0 over %0d cycles", cyc + 1);
  endtask

  task automatic test_underrun();
    logic [4:0] obs, want;
    int cyc;
    load_src(32'b01, 2, 1'b0);
    push_frame(32'b01, 2, 1'b0);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL underrun cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_underrun: 2 bits then starvation over %0d cycles", cyc + 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] obs, want;
    int cyc;
    load_src(32'b1101, 4, 1'b1);
    push_frame(32'b1101, 4, 1'b1);
    // Entry 0 is the IDLE cycle, so entry 201 is frame cycle 200 (rst high).
    for (int c = 0; c < 202; c++) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d: outputs=%b expected %b", c - 1, obs, want);
      end
      if (c == 200) rst = 1'b1;
    end
    rst = 1'b0;
    src_en = 1'b0;
    drive_inputs();
    exp_q.delete();
    for (int c = 0; c < 20; c++) exp_q.push_back(5'b00000);
    cyc = 201;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mid_reset_idle cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    load_src(32'b00, 2, 1'b1);
    push_frame(32'b00, 2, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mid_reset_restart cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_reset_mid_frame: reset at cycle 200, restart frame 0,0 over %0d cycles", cyc + 1);
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs, want;
    int cyc;
    load_src(32'b011, 3, 1'b1);
    push_frame(32'b011, 3, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL back_to_back_a cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    load_src(32'b10, 2, 1'b1);
    push_frame(32'b10, 2, 1'b1);
    cyc = -1;
    while (exp_q.size() > 0) begin
      step(obs);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL back_to_back_b cycle %0d: outputs=%b expected %b", cyc, obs, want);
      end
      cyc++;
    end
    $display("test_back_to_back: frames 1,1,0 and 0,1 without gap");
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 1'b0;
    in_last  = 1'b0;
    src_bits = '0;
    src_n    = 0;
    idx      = 0;
    src_last = 1'b0;
    src_en   = 1'b0;
    test_reset();
    test_single_bit();
    test_frame_0110();
    test_underrun();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
